// File: rtl/cpu_pkg.sv
// Shared PC-source and FSM types plus default vectors for the pipelined MIPS core.
package cpu_pkg;

  typedef enum logic [2:0] {
    PCSRC_SEQ,
    PCSRC_BR,
    PCSRC_J,
    PCSRC_JR,
    PCSRC_ILLOP,
    PCSRC_XADR
  } pcsrc_e;

  typedef enum logic [0:0] {
    RUN,
    HOLD
  } pc_state_e;

  localparam logic [31:0] DEF_START_ADDR = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_ADDR = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_ADDR  = 32'h8000_0008;
  localparam int unsigned DEF_STEP       = 4;

  function automatic logic is_vector(input pcsrc_e src);
    return (src == PCSRC_ILLOP) || (src == PCSRC_XADR);
  endfunction

endpackage

// File: rtl/cpu_pc_arbiter.sv
// Combinational fixed-priority PC source encoder: exc > irq > branch > JR > J > sequential.
module cpu_pc_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] ILLOP_ADDR = ADDR_W'(DEF_ILLOP_ADDR),
  parameter logic [ADDR_W-1:0] XADR_ADDR  = ADDR_W'(DEF_XADR_ADDR),
  parameter int unsigned       STEP       = DEF_STEP
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              exc_i,
  input  logic              irq_take_i,
  input  logic              br_take_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              jr_valid_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  input  logic              j_valid_i,
  input  logic [25:0]       j_index_i,
  output logic [ADDR_W-1:0] pc_plus_o,
  output pcsrc_e            lo_src_o,
  output logic [ADDR_W-1:0] lo_pc_o,
  output pcsrc_e            src_o,
  output logic [ADDR_W-1:0] next_pc_o
);

  localparam int unsigned    LoW    = ADDR_W - 1;
  localparam logic [LoW-1:0] StepLo = LoW'(STEP);

  logic              kernel;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] jr_eff;

  assign kernel    = pc_i[ADDR_W-1];
  // Low bits wrap on their own; the kernel bit is never carried into.
  assign pc_plus_o = {kernel, pc_i[LoW-1:0] + StepLo};
  assign j_target  = {pc_i[ADDR_W-1:28], j_index_i, 2'b00};
  // JR may clear the kernel bit but never set it.
  assign jr_eff    = {kernel & jr_target_i[ADDR_W-1], jr_target_i[LoW-1:0]};

  always_comb begin
    lo_src_o = PCSRC_SEQ;
    lo_pc_o  = pc_plus_o;
    if (br_take_i) begin
      lo_src_o = PCSRC_BR;
      lo_pc_o  = br_target_i;
    end else if (jr_valid_i) begin
      lo_src_o = PCSRC_JR;
      lo_pc_o  = jr_eff;
    end else if (j_valid_i) begin
      lo_src_o = PCSRC_J;
      lo_pc_o  = j_target;
    end
  end

  always_comb begin
    src_o     = lo_src_o;
    next_pc_o = lo_pc_o;
    if (exc_i) begin
      src_o     = PCSRC_XADR;
      next_pc_o = {1'b1, XADR_ADDR[LoW-1:0]};
    end else if (irq_take_i) begin
      src_o     = PCSRC_ILLOP;
      next_pc_o = {1'b1, ILLOP_ADDR[LoW-1:0]};
    end
  end

endmodule

// File: rtl/cpu_pc_unit.sv
// IF-stage program-counter unit: redirect arbitration, stall holding, EPC capture, flushes.
// Defining PC_ALIGN_CHECK_EN traps misaligned branch/JR/held targets to the exception vector.
module cpu_pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR),
  parameter logic [ADDR_W-1:0] ILLOP_ADDR = ADDR_W'(DEF_ILLOP_ADDR),
  parameter logic [ADDR_W-1:0] XADR_ADDR  = ADDR_W'(DEF_XADR_ADDR),
  parameter int unsigned       STEP       = DEF_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              j_valid,
  input  logic [25:0]       j_index,
  input  logic              jr_valid,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              irq,
  input  logic              exc,
  input  logic [ADDR_W-1:0] exc_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              kernel,
  output logic [ADDR_W-1:0] epc,
  output logic              flush_if,
  output logic              flush_id,
  output logic              redirect_pending
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic              hold_br_q, hold_br_d;
  logic              irq_pend_q, irq_pend_d;

  logic              in_run;
  logic              br_take;
  logic              irq_pend;
  logic              irq_take;
  logic              align_exc;
  logic              exc_any;
  logic              vector;
  pcsrc_e            lo_src;
  pcsrc_e            arb_src;
  logic [ADDR_W-1:0] lo_pc;
  logic [ADDR_W-1:0] arb_pc;
  logic [ADDR_W-1:0] ret_pc;

  assign kernel   = pc_q[ADDR_W-1];
  assign in_run   = (state_q == RUN);
  assign br_take  = br_valid & br_taken;
  assign irq_pend = irq_pend_q | irq;
  assign irq_take = irq_pend & ~kernel;

`ifdef PC_ALIGN_CHECK_EN
  assign align_exc = (br_take & (|br_target[1:0]))
                   | (in_run & ~br_take & jr_valid & (|jr_target[1:0]))
                   | (~in_run & ~br_take & ~stall & (|hold_pc_q[1:0]));
`else
  assign align_exc = 1'b0;
`endif

  assign exc_any = exc | align_exc;
  assign vector  = exc_any | irq_take;

  // In HOLD the stalled ID-stage jump is already captured; only a branch may still compete.
  cpu_pc_arbiter #(
    .ADDR_W     (ADDR_W),
    .ILLOP_ADDR (ILLOP_ADDR),
    .XADR_ADDR  (XADR_ADDR),
    .STEP       (STEP)
  ) u_arbiter (
    .pc_i        (pc_q),
    .exc_i       (exc_any),
    .irq_take_i  (irq_take),
    .br_take_i   (br_take),
    .br_target_i (br_target),
    .jr_valid_i  (jr_valid & in_run),
    .jr_target_i (jr_target),
    .j_valid_i   (j_valid & in_run),
    .j_index_i   (j_index),
    .pc_plus_o   (pc_plus),
    .lo_src_o    (lo_src),
    .lo_pc_o     (lo_pc),
    .src_o       (arb_src),
    .next_pc_o   (arb_pc)
  );

  // Address that would load absent a vector: held target unless a newer branch replaces it.
  assign ret_pc = (!in_run && (lo_src == PCSRC_SEQ)) ? hold_pc_q : lo_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (!vector && stall && (lo_src != PCSRC_SEQ)) state_d = HOLD;
      HOLD:    if (vector || !stall) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    hold_pc_d  = hold_pc_q;
    hold_br_d  = hold_br_q;
    irq_pend_d = irq_take ? 1'b0 : irq_pend;
    if (vector) begin
      pc_d      = arb_pc;
      epc_d     = exc_any ? (exc ? exc_pc : pc_q) : ret_pc;
      hold_br_d = 1'b0;
    end else if (stall) begin
      if (lo_src != PCSRC_SEQ) begin
        hold_pc_d = lo_pc;
        hold_br_d = (lo_src == PCSRC_BR);
      end
    end else begin
      pc_d = ret_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= START_ADDR;
      epc_q      <= '0;
      hold_pc_q  <= '0;
      hold_br_q  <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      hold_pc_q  <= hold_pc_d;
      hold_br_q  <= hold_br_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  always_comb begin
    redirect_pending = ~reset & (state_q == HOLD);
    flush_if         = 1'b0;
    flush_id         = 1'b0;
    if (!reset) begin
      if (is_vector(arb_src)) begin
        flush_if = 1'b1;
        flush_id = 1'b1;
      end else if (!stall) begin
        if (lo_src == PCSRC_BR) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else if (lo_src != PCSRC_SEQ) begin
          flush_if = 1'b1;
        end else if (!in_run) begin
          flush_if = 1'b1;
          flush_id = hold_br_q;
        end
      end
    end
  end

  assign pc  = pc_q;
  assign epc = epc_q;

endmodule

// File: tb/tb_cpu_pc_unit.sv
// Scoreboard bench for cpu_pc_unit: expectations are queued when stimulus is driven and
// compared at the following negedge(s) of the clock.
module tb_cpu_pc_unit;

  localparam int SelPc     = 0;
  localparam int SelEpc    = 1;
  localparam int SelFlIf   = 2;
  localparam int SelFlId   = 3;
  localparam int SelPend   = 4;
  localparam int SelKernel = 5;
  localparam int SelPlus   = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
    int          due;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        j_valid;
  logic [25:0] j_index;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic        irq;
  logic        exc;
  logic [31:0] exc_pc;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        kernel;
  logic [31:0] epc;
  logic        flush_if;
  logic        flush_id;
  logic        redirect_pending;

  int   n_tests;
  int   n_fail;
  int   cyc;
  exp_t sb[$];

  cpu_pc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .br_valid         (br_valid),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .j_valid          (j_valid),
    .j_index          (j_index),
    .jr_valid         (jr_valid),
    .jr_target        (jr_target),
    .irq              (irq),
    .exc              (exc),
    .exc_pc           (exc_pc),
    .pc               (pc),
    .pc_plus          (pc_plus),
    .kernel           (kernel),
    .epc              (epc),
    .flush_if         (flush_if),
    .flush_id         (flush_id),
    .redirect_pending (redirect_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      SelPc:     return pc;
      SelEpc:    return epc;
      SelFlIf:   return {31'b0, flush_if};
      SelFlId:   return {31'b0, flush_id};
      SelPend:   return {31'b0, redirect_pending};
      SelKernel: return {31'b0, kernel};
      default:   return pc_plus;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check_eq(e.tag, obs(e.sel), e.val);
    end
  end

  task automatic exp_now(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v; e.due = cyc;
    sb.push_back(e);
  endtask

  task automatic exp_next(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v; e.due = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; stall = 1'b0;
    br_valid = 1'b0; br_taken = 1'b0; br_target = '0;
    j_valid = 1'b0; j_index = '0; jr_valid = 1'b0; jr_target = '0;
    irq = 1'b0; exc = 1'b0; exc_pc = '0;

    // Reset held with exc/irq asserted: no flush or pending may leak out.
    step();
    exc = 1'b1; irq = 1'b1;
    exp_now("rst_flush_if", SelFlIf, 0);
    exp_now("rst_flush_id", SelFlId, 0);
    exp_now("rst_pend", SelPend, 0);
    exp_next("rst_pc", SelPc, 32'h8000_0000);
    exp_next("rst_epc", SelEpc, 32'h0);

    step();
    reset = 1'b0; exc = 1'b0; irq = 1'b0;
    exp_now("free0_plus", SelPlus, 32'h8000_0004);
    exp_now("free0_kernel", SelKernel, 1);
    exp_next("free1", SelPc, 32'h8000_0004);
    step();
    exp_next("free2", SelPc, 32'h8000_0008);

    step();
    jr_valid = 1'b1; jr_target = 32'hFFFF_FFFC;
    exp_now("jr_flush_if", SelFlIf, 1);
    exp_now("jr_flush_id", SelFlId, 0);
    exp_next("jr_top", SelPc, 32'hFFFF_FFFC);
    step();
    jr_valid = 1'b0;
    exp_now("wrap_plus", SelPlus, 32'h8000_0000);
    exp_next("wrap_pc", SelPc, 32'h8000_0000);

    step();
    jr_valid = 1'b1; jr_target = 32'h0000_0100;
    exp_next("to_user", SelPc, 32'h0000_0100);
    exp_next("to_user_k", SelKernel, 0);
    step();
    jr_valid = 1'b0; br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0200;
    exp_now("br_flush_if", SelFlIf, 1);
    exp_now("br_flush_id", SelFlId, 1);
    exp_next("br_taken_pc", SelPc, 32'h0000_0200);
    step();
    br_valid = 1'b0; jr_valid = 1'b1; jr_target = 32'h0000_0100;
    step();
    jr_valid = 1'b0; br_valid = 1'b1; br_taken = 1'b0;
    exp_now("bnt_flush_if", SelFlIf, 0);
    exp_now("bnt_flush_id", SelFlId, 0);
    exp_next("br_not_taken_pc", SelPc, 32'h0000_0104);

    step();
    br_valid = 1'b0; jr_valid = 1'b1; jr_target = 32'h0000_0040;
    step();
    jr_target = 32'h8000_1000;
    exp_next("jr_kblock", SelPc, 32'h0000_1000);
    step();
    jr_valid = 1'b0; exc = 1'b1; exc_pc = 32'h0000_1000;
    exp_now("exc_flush_id", SelFlId, 1);
    exp_next("exc_pc", SelPc, 32'h8000_0008);
    exp_next("exc_epc", SelEpc, 32'h0000_1000);
    step();
    exc = 1'b0; jr_valid = 1'b1; jr_target = 32'h8000_0040;
    step();
    jr_target = 32'h0000_1000;
    exp_next("jr_kexit", SelPc, 32'h0000_1000);
    step();
    jr_target = 32'h0000_0010;

    // J under a three-cycle stall is held, then released.
    step();
    jr_valid = 1'b0; stall = 1'b1; j_valid = 1'b1; j_index = 26'h40;
    exp_now("stall_pend0", SelPend, 0);
    exp_now("stall_noflush", SelFlIf, 0);
    exp_next("stall_pc1", SelPc, 32'h0000_0010);
    exp_next("stall_pend1", SelPend, 1);
    step();
    exp_next("stall_pc2", SelPc, 32'h0000_0010);
    step();
    exp_now("hold_noflush", SelFlIf, 0);
    exp_next("stall_pc3", SelPc, 32'h0000_0010);
    exp_next("stall_pend3", SelPend, 1);
    step();
    stall = 1'b0; j_valid = 1'b0;
    exp_now("rel_flush_if", SelFlIf, 1);
    exp_now("rel_flush_id", SelFlId, 0);
    exp_next("rel_pc", SelPc, 32'h0000_0100);
    exp_next("rel_pend", SelPend, 0);

    step();
    jr_valid = 1'b1; jr_target = 32'h0000_0020;
    step();
    jr_valid = 1'b0; irq = 1'b1;
    exp_now("irq_flush_id", SelFlId, 1);
    exp_next("irq_pc", SelPc, 32'h8000_0004);
    exp_next("irq_epc", SelEpc, 32'h0000_0024);
    step();
    irq = 1'b0; jr_valid = 1'b1; jr_target = 32'h8000_0100;
    step();
    jr_valid = 1'b0; irq = 1'b1;
    exp_now("irq_k_noflush", SelFlIf, 0);
    exp_next("irq_k_pc", SelPc, 32'h8000_0104);
    exp_next("irq_k_epc", SelEpc, 32'h0000_0024);
    step();
    irq = 1'b0;
    exp_next("irq_k_pc2", SelPc, 32'h8000_0108);
    step();
    jr_valid = 1'b1; jr_target = 32'h0000_0300;
    exp_next("irq_k_exit", SelPc, 32'h0000_0300);
    step();
    jr_valid = 1'b0;
    exp_now("irq_late_flush", SelFlIf, 1);
    exp_next("irq_late_pc", SelPc, 32'h8000_0004);
    exp_next("irq_late_epc", SelEpc, 32'h0000_0304);

    // Exception while a stalled branch is held discards the held target.
    step();
    stall = 1'b1; br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0500;
    exp_next("hbr_pc", SelPc, 32'h8000_0004);
    exp_next("hbr_pend", SelPend, 1);
    step();
    br_valid = 1'b0; br_taken = 1'b0; exc = 1'b1; exc_pc = 32'h0000_0030;
    exp_now("hexc_flush_if", SelFlIf, 1);
    exp_now("hexc_flush_id", SelFlId, 1);
    exp_next("hexc_pc", SelPc, 32'h8000_0008);
    exp_next("hexc_epc", SelEpc, 32'h0000_0030);
    exp_next("hexc_pend", SelPend, 0);
    step();
    exc = 1'b0; stall = 1'b0;
    exp_now("post_noflush", SelFlIf, 0);
    exp_next("hexc_discard", SelPc, 32'h8000_000C);

    step();
    br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0202;
`ifdef PC_ALIGN_CHECK_EN
    exp_now("align_flush_id", SelFlId, 1);
    exp_next("align_pc", SelPc, 32'h8000_0008);
    exp_next("align_epc", SelEpc, 32'h8000_000C);
`else
    exp_next("misalign_pass", SelPc, 32'h0000_0202);
`endif
    step();
    br_valid = 1'b0; br_taken = 1'b0;

    for (int i = 0; i < 5 && sb.size() > 0; i++) step();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: got unchecked expected %h", e.tag, e.val);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_pc_unit.md
Name: cpu_pc_unit

Overview:
Parametrised program-counter unit for the pipelined MIPS core, the successor to the single-cycle PC source mux. It arbitrates sequential fetch, conditional branch, J/JAL, JR/JALR, interrupt and exception redirects by fixed priority. It adds stall handling, holding of redirects that arrive during a stall, kernel-bit (PC[MSB]) protection, EPC capture and pipeline flush outputs. It sits at the IF stage and drives the instruction memory address.

Parameters:
ADDR_W, 32, PC width; MSB is the kernel/supervisor bit
START_ADDR, 32'h8000_0000, reset vector
ILLOP_ADDR, 32'h8000_0004, interrupt vector
XADR_ADDR, 32'h8000_0008, exception vector
STEP, 4, sequential increment in bytes

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC
br_valid  in  1  EX-stage conditional branch resolved this cycle
br_taken  in  1  branch condition result (ALU output bit 0)
br_target  in  ADDR_W  branch target (ConBA)
j_valid  in  1  ID-stage J/JAL
j_index  in  26  jump index field
jr_valid  in  1  ID-stage JR/JALR
jr_target  in  ADDR_W  register-file read port A
irq  in  1  level interrupt request
exc  in  1  illegal/undefined instruction, one-cycle pulse
exc_pc  in  ADDR_W  PC of the faulting instruction
pc  out  ADDR_W  current fetch address
pc_plus  out  ADDR_W  pc + STEP, MSB preserved
kernel  out  1  equals pc[ADDR_W-1]
epc  out  ADDR_W  captured return address
flush_if  out  1  squash the IF/ID register
flush_id  out  1  squash the ID/EX register
redirect_pending  out  1  a redirect is being held across a stall

Behaviour:
- One clock. Reset is synchronous and active-high: on clk rise with reset=1, set pc=START_ADDR, epc=0, state=RUN, all pending registers=0. flush_if, flush_id and redirect_pending are 0 during reset.
- Arithmetic: pc_plus={pc[MSB], pc[MSB-1:0]+STEP}. The lower bits wrap modulo 2^(ADDR_W-1) and never toggle the MSB. Jump target={pc[MSB:28], j_index, 2'b00}.
- Kernel protection: a JR target loads {pc[MSB] & jr_target[MSB], jr_target[MSB-1:0]}. User mode cannot enter kernel mode through JR, but kernel mode can leave it. Vectors always set the MSB.
- Redirect priority, highest first: exc > irq_take > (br_valid & br_taken) > jr_valid > j_valid > sequential. irq_take = irq_pend & ~kernel.
- irq_pend is set by irq=1 and cleared when the interrupt is taken or by reset. An interrupt is never taken while kernel=1.
- exc and irq_take override stall. The PC loads the vector in the same cycle, and flush_if and flush_id are driven to 1 combinationally.
- On exc: epc<=exc_pc. On irq_take: epc<=the address that would otherwise have loaded (the winning lower-priority target or pc_plus).
- Taken branch: flush_if=flush_id=1. J/JR: flush_if=1 only. Redirects load on the next clk rise.
- FSM states:
  - RUN: stall=0 means load the winner. If stall=1 and a branch/J/JR redirect is asserted, latch the target into hold_pc, go to HOLD and keep pc.
  - HOLD: redirect_pending=1 and pc is held. When stall=0, load hold_pc and return to RUN. A new exc or irq_take in HOLD wins, discards hold_pc and goes to RUN. A new taken branch in HOLD overwrites hold_pc, because it is older in program order than the ID-stage jump.
- stall=1 with no redirect: pc holds and no flush is driven.
- br_valid with br_taken=0 is equivalent to no branch.
- Simultaneous taken branch and J/JR: the branch wins and the jump is squashed by flush_if.
- Reset mid-HOLD discards the held target.
- Unused encodings are unreachable: a single-bit state register with the default case forcing RUN.

Optional Feature:
PC_ALIGN_CHECK_EN: when defined, any branch, JR or hold_pc target with [1:0]!=0 is treated as exc with exc_pc=pc. The PC loads XADR_ADDR, epc=pc and both flushes are driven. When undefined, targets load unchecked and the low bits pass through.

Decomposition:
- Shared package cpu_pkg holds:
  - the PC source enum (PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR, PCSRC_ILLOP, PCSRC_XADR)
  - the FSM state typedef (RUN, HOLD)
  - default vector constants
- One sub-module, cpu_pc_arbiter: a combinational priority encoder producing the source select and next_pc. The top module holds pc, epc, hold_pc, irq_pend and the FSM.

Test Plan:
- Reset then 3 free cycles → pc=8000_0000, 8000_0004, 8000_0008. Preset pc=FFFF_FFFC with sequential fetch → next pc=8000_0000 (MSB kept, low bits wrap).
- User pc=0000_0100, br_valid=1, br_taken=1, br_target=0000_0200 → next pc=0000_0200 with flush_if=flush_id=1. Same inputs with br_taken=0 → pc=0000_0104.
- User pc=0000_0040, jr_valid=1, jr_target=8000_1000 → pc=0000_1000 (kernel bit blocked). From kernel pc=8000_0040, jr_target=0000_1000 → pc=0000_1000.
- stall=1 with j_valid=1, j_index=26'h40 at pc=0000_0010, stall held 3 cycles → pc stays 0000_0010 and redirect_pending=1. stall drops → pc=0000_0100.
- irq=1 at user pc=0000_0020 → pc=8000_0004, epc=0000_0024. irq=1 while pc=8000_0100 → not taken until the PC returns to user mode.
- exc=1, exc_pc=0000_0030 while in HOLD with a pending branch → pc=8000_0008, epc=0000_0030, pending target discarded. With PC_ALIGN_CHECK_EN, br_target=0000_0202 → pc=8000_0008.
